// File: rtl/width_pack_arbiter_pkg.sv
// Shared types and constants for the two-requester 8-to-16 packing arbiter.
package width_pack_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HALF = 1'b1
  } state_t;

  localparam int TIMEOUT_DEFAULT = 15;
  localparam int REQ_IDX_W       = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin winner selection: a tie goes to the requester that did not own the last word.
module rr_arb2
  import width_pack_arbiter_pkg::*;
(
  input  logic [1:0]           valid,
  input  logic [REQ_IDX_W-1:0] last_owner,
  output logic [REQ_IDX_W-1:0] winner
);

  always_comb begin
    winner = '0;
    if (valid == 2'b11) begin
      winner = ~last_owner;
    end else if (valid[1]) begin
      winner = REQ_IDX_W'(1);
    end
  end

endmodule

// File: rtl/width_pack_arbiter.sv
// Packs byte pairs from two requesters into 16-bit words, granting one whole word at a time
// and dropping a half-built word if its owner stalls for TIMEOUT cycles.
module width_pack_arbiter
  import width_pack_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  output logic        req1_ready,
  output logic        valid_out,
  output logic [15:0] data_out,
  output logic        src_out,
  output logic        err_drop
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t               state, state_next;
  logic [REQ_IDX_W-1:0] owner, last_owner, winner;
  logic [7:0]           cnt, cnt_inc, high_byte, win_data, owner_data;
  logic                 any_valid, owner_valid;
  logic                 take_first, complete, drop;

  rr_arb2 u_rr_arb2 (
    .valid      ({req1_valid, req0_valid}),
    .last_owner (last_owner),
    .winner     (winner)
  );

  assign any_valid   = req0_valid | req1_valid;
  assign win_data    = winner[0] ? req1_data : req0_data;
  assign owner_valid = owner[0] ? req1_valid : req0_valid;
  assign owner_data  = owner[0] ? req1_data : req0_data;
  assign cnt_inc     = cnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The non-owner is held off for the whole of HALF so bytes of two words never interleave.
  always_comb begin
    state_next = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    take_first = 1'b0;
    complete   = 1'b0;
    drop       = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = any_valid & ~winner[0];
        req1_ready = any_valid & winner[0];
        if (any_valid) begin
          take_first = 1'b1;
          state_next = HALF;
        end
      end
      HALF: begin
        req0_ready = ~owner[0];
        req1_ready = owner[0];
        if (owner_valid) begin
          complete   = 1'b1;
          state_next = IDLE;
        end else if (cnt_inc == TIMEOUT_CNT) begin
          drop       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= '0;
      last_owner <= REQ_IDX_W'(1);
      cnt        <= '0;
      high_byte  <= '0;
      valid_out  <= 1'b0;
      data_out   <= '0;
      src_out    <= 1'b0;
      err_drop   <= 1'b0;
    end else begin
      valid_out <= complete;
      err_drop  <= drop;
      if (take_first) begin
        high_byte <= win_data;
        owner     <= winner;
        cnt       <= '0;
      end else if (state == HALF && !owner_valid && !drop) begin
        cnt <= cnt_inc;
      end
      if (complete) begin
        data_out   <= {high_byte, owner_data};
        src_out    <= owner[0];
        last_owner <= owner;
        high_byte  <= '0;
      end
      if (drop) begin
        last_owner <= owner;
        high_byte  <= '0;
        cnt        <= '0;
      end
    end
  end

endmodule

// File: tb/tb_width_pack_arbiter.sv
// Directed self-checking bench for width_pack_arbiter with hand-computed expected values.
module tb_width_pack_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid;
  logic [7:0]  req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [7:0]  req1_data;
  logic        req1_ready;
  logic        valid_out;
  logic [15:0] data_out;
  logic        src_out;
  logic        err_drop;

  int checks = 0;
  int errors = 0;

  width_pack_arbiter #(.TIMEOUT(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .valid_out  (valid_out),
    .data_out   (data_out),
    .src_out    (src_out),
    .err_drop   (err_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge, where registered outputs are stable.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = 8'h00;
    req1_data  = 8'h00;
    rst_n      = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid_out got %0b exp 0", valid_out); end
    checks++; if (data_out !== 16'h0000) begin errors++; $display("[TB] FAIL reset_data_out got %h exp 0000", data_out); end
    checks++; if (src_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_src_out got %0b exp 0", src_out); end
    checks++; if (err_drop !== 1'b0) begin errors++; $display("[TB] FAIL reset_err_drop got %0b exp 0", err_drop); end
    checks++; if ({req1_ready, req0_ready} !== 2'b00) begin errors++; $display("[TB] FAIL reset_readies got %b exp 00", {req1_ready, req0_ready}); end
  endtask

  task automatic test_basic_word();
    req0_valid = 1'b1; req0_data = 8'hA5;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("[TB] FAIL basic_ready_first got %b exp 01", {req1_ready, req0_ready}); end
    step();
    req0_data = 8'h3C;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_ready_second got %0b exp 1", req0_ready); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_valid got %0b exp 0", valid_out); end
    step();
    req0_valid = 1'b0;
    checks++; if (valid_out !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid_out got %0b exp 1", valid_out); end
    checks++; if (data_out !== 16'hA53C) begin errors++; $display("[TB] FAIL basic_data_out got %h exp a53c", data_out); end
    checks++; if (src_out !== 1'b0) begin errors++; $display("[TB] FAIL basic_src_out got %0b exp 0", src_out); end
    step();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL basic_valid_pulse got %0b exp 0", valid_out); end
    checks++; if (data_out !== 16'hA53C) begin errors++; $display("[TB] FAIL basic_data_hold got %h exp a53c", data_out); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req0_valid = 1'b1; req0_data = 8'h11;
    req1_valid = 1'b1; req1_data = 8'h33;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("[TB] FAIL b2b_first_tie got %b exp 01", {req1_ready, req0_ready}); end
    step();
    req0_data = 8'h22;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("[TB] FAIL b2b_half_lock got %b exp 01", {req1_ready, req0_ready}); end
    step();
    checks++; if (valid_out !== 1'b1) begin errors++; $display("[TB] FAIL b2b_word0_valid got %0b exp 1", valid_out); end
    checks++; if (data_out !== 16'h1122) begin errors++; $display("[TB] FAIL b2b_word0_data got %h exp 1122", data_out); end
    checks++; if (src_out !== 1'b0) begin errors++; $display("[TB] FAIL b2b_word0_src got %0b exp 0", src_out); end
    checks++; if ({req1_ready, req0_ready} !== 2'b10) begin errors++; $display("[TB] FAIL b2b_second_tie got %b exp 10", {req1_ready, req0_ready}); end
    step();
    req1_data = 8'h44;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b10) begin errors++; $display("[TB] FAIL b2b_half_lock1 got %b exp 10", {req1_ready, req0_ready}); end
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    checks++; if (valid_out !== 1'b1) begin errors++; $display("[TB] FAIL b2b_word1_valid got %0b exp 1", valid_out); end
    checks++; if (data_out !== 16'h3344) begin errors++; $display("[TB] FAIL b2b_word1_data got %h exp 3344", data_out); end
    checks++; if (src_out !== 1'b1) begin errors++; $display("[TB] FAIL b2b_word1_src got %0b exp 1", src_out); end
    step();
  endtask

  task automatic test_timeout();
    int early_err;
    req1_valid = 1'b1; req1_data = 8'h7E;
    step();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h55;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b10) begin errors++; $display("[TB] FAIL timeout_lock got %b exp 10", {req1_ready, req0_ready}); end
    early_err = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (err_drop !== 1'b0 || valid_out !== 1'b0) early_err++;
    end
    checks++; if (early_err !== 0) begin errors++; $display("[TB] FAIL timeout_early got %0d pulses exp 0", early_err); end
    step();
    req1_valid = 1'b1; req1_data = 8'h99;
    checks++; if (err_drop !== 1'b1) begin errors++; $display("[TB] FAIL timeout_err_drop got %0b exp 1", err_drop); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL timeout_valid_out got %0b exp 0", valid_out); end
    checks++; if (data_out !== 16'h3344) begin errors++; $display("[TB] FAIL timeout_data_hold got %h exp 3344", data_out); end
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("[TB] FAIL timeout_next_grant got %b exp 01", {req1_ready, req0_ready}); end
    step();
    req0_data = 8'h66;
    checks++; if (err_drop !== 1'b0) begin errors++; $display("[TB] FAIL timeout_err_pulse got %0b exp 0", err_drop); end
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    checks++; if (data_out !== 16'h5566 || src_out !== 1'b0) begin errors++; $display("[TB] FAIL timeout_after_word got %h/%0b exp 5566/0", data_out, src_out); end
    step();
  endtask

  task automatic test_near_timeout();
    int early_err;
    req1_valid = 1'b1; req1_data = 8'h7E;
    step();
    req1_valid = 1'b0;
    early_err = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (err_drop !== 1'b0 || valid_out !== 1'b0) early_err++;
    end
    checks++; if (early_err !== 0) begin errors++; $display("[TB] FAIL near_early got %0d pulses exp 0", early_err); end
    req1_valid = 1'b1; req1_data = 8'h81;
    step();
    req1_valid = 1'b0;
    checks++; if (valid_out !== 1'b1) begin errors++; $display("[TB] FAIL near_valid_out got %0b exp 1", valid_out); end
    checks++; if (data_out !== 16'h7E81) begin errors++; $display("[TB] FAIL near_data_out got %h exp 7e81", data_out); end
    checks++; if (src_out !== 1'b1) begin errors++; $display("[TB] FAIL near_src_out got %0b exp 1", src_out); end
    checks++; if (err_drop !== 1'b0) begin errors++; $display("[TB] FAIL near_err_drop got %0b exp 0", err_drop); end
    step();
  endtask

  task automatic test_reset_half();
    req0_valid = 1'b1; req0_data = 8'hFF;
    step();
    req0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (valid_out !== 1'b0 || err_drop !== 1'b0) begin errors++; $display("[TB] FAIL rsthalf_pulses got %0b/%0b exp 0/0", valid_out, err_drop); end
    checks++; if (data_out !== 16'h0000 || src_out !== 1'b0) begin errors++; $display("[TB] FAIL rsthalf_data got %h/%0b exp 0000/0", data_out, src_out); end
    checks++; if ({req1_ready, req0_ready} !== 2'b00) begin errors++; $display("[TB] FAIL rsthalf_readies got %b exp 00", {req1_ready, req0_ready}); end
    step();
    rst_n = 1'b1;
    step();
    checks++; if (valid_out !== 1'b0 || err_drop !== 1'b0) begin errors++; $display("[TB] FAIL rsthalf_release got %0b/%0b exp 0/0", valid_out, err_drop); end
    req0_valid = 1'b1; req0_data = 8'h01;
    step();
    req0_data = 8'h02;
    step();
    req0_valid = 1'b0;
    checks++; if (valid_out !== 1'b1) begin errors++; $display("[TB] FAIL rsthalf_valid_out got %0b exp 1", valid_out); end
    checks++; if (data_out !== 16'h0102 || src_out !== 1'b0) begin errors++; $display("[TB] FAIL rsthalf_word got %h/%0b exp 0102/0", data_out, src_out); end
    step();
  endtask

  initial begin
    test_reset();
    test_basic_word();
    test_back_to_back();
    test_timeout();
    test_near_timeout();
    test_reset_half();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
